// File: rtl/bram_pkg.sv
// Shared types and helpers for the multi-port BRAM.
//   rdw_mode_e  : read-during-write mode (old data / forwarded new data)
//   clr_state_e : post-reset clear sequencer states
//   byte_merge  : overlays the enabled bytes of a new word onto an old word
package bram_pkg;

    typedef enum logic {
        RDW_OLD = 1'b0,
        RDW_NEW = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    // byte_merge works on the widest supported word; callers zero-extend
    // their operands and keep only the low WIDTH bits of the result.
    localparam int unsigned MAX_WIDTH = 1024;
    localparam int unsigned MAX_BYTES = MAX_WIDTH / 8;

    function automatic logic [MAX_WIDTH-1:0] byte_merge(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_WIDTH-1:0] res;
        res = old_word;
        for (int unsigned b = 0; b < MAX_BYTES; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_wr_merge.sv
// Combinational collision resolver / byte merger for one target address.
// Starting from old_word, every write port hitting addr overlays its enabled
// bytes in ascending port order, so the highest-index writer of each byte wins.
//   addr        : address being resolved
//   old_word    : current array contents at addr
//   wr_en       : per-port write request (already qualified)
//   wr_addr     : per-port write address
//   wr_be       : per-port byte enables
//   wr_data     : per-port write data
//   merged_word : word as it will read after this cycle's writes
module bram_wr_merge
    import bram_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_WR = 2
) (
    input  logic [$clog2(DEPTH)-1:0]              addr,
    input  logic [WIDTH-1:0]                      old_word,
    input  logic [NUM_WR-1:0]                     wr_en,
    input  logic [NUM_WR-1:0][$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [NUM_WR-1:0][WIDTH/8-1:0]        wr_be,
    input  logic [NUM_WR-1:0][WIDTH-1:0]          wr_data,
    output logic [WIDTH-1:0]                      merged_word
);

    logic [MAX_WIDTH-1:0] acc;

    always_comb begin
        acc = MAX_WIDTH'(old_word);
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && (wr_addr[i] == addr)) begin
                acc = byte_merge(acc, MAX_WIDTH'(wr_data[i]), MAX_BYTES'(wr_be[i]));
            end
        end
        merged_word = acc[WIDTH-1:0];
    end

endmodule

// File: rtl/bram_mp_pipe.sv
// Multi-port on-chip RAM with per-byte write enables, deterministic
// multi-writer priority, selectable read-during-write, a RD_LATENCY-deep
// read pipeline with valid tracking and a post-reset clear sequencer.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   rd_en     : per-port read request
//   rd_addr   : per-port read address
//   rd_data   : per-port read data (holds when rd_valid is low)
//   rd_valid  : per-port read data qualifier, RD_LATENCY cycles after rd_en
//   wr_en     : per-port write request
//   wr_addr   : per-port write address
//   wr_be     : per-port byte enables
//   wr_data   : per-port write data
//   init_busy : clear sequence in progress; all requests ignored
module bram_mp_pipe #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned NUM_RD         = 2,
    parameter int unsigned NUM_WR         = 2,
    parameter int unsigned RD_LATENCY     = 1,
    parameter bit          RDW_NEW        = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_RD-1:0]                     rd_en,
    input  logic [NUM_RD-1:0][$clog2(DEPTH)-1:0]  rd_addr,
    output logic [NUM_RD-1:0][WIDTH-1:0]          rd_data,
    output logic [NUM_RD-1:0]                     rd_valid,
    input  logic [NUM_WR-1:0]                     wr_en,
    input  logic [NUM_WR-1:0][$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [NUM_WR-1:0][WIDTH/8-1:0]        wr_be,
    input  logic [NUM_WR-1:0][WIDTH-1:0]          wr_data,
    output logic                                  init_busy
);
    import bram_pkg::*;

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam rdw_mode_e   RdwMode = RDW_NEW ? bram_pkg::RDW_NEW : bram_pkg::RDW_OLD;
    localparam clr_state_e  ResetState = CLEAR_ON_RESET ? CLEAR : READY;

    logic [WIDTH-1:0] mem [DEPTH];

    // ---------------------------------------------------------------
    // Clear sequencer
    // ---------------------------------------------------------------
    clr_state_e       state_q, state_d;
    logic [AddrW-1:0] cnt_q, cnt_d;
    logic             busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ResetState;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AddrW'(1);
                if (cnt_q == AddrW'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == CLEAR);
    end

    assign init_busy = busy;

    // Requests are dropped entirely while the clear runs.
    logic [NUM_WR-1:0] wr_act;
    logic [NUM_RD-1:0] rd_req;

    assign wr_act = wr_en & {NUM_WR{~busy}};
    assign rd_req = rd_en & {NUM_RD{~busy}};

    // ---------------------------------------------------------------
    // Write path: every enabled port stores the fully resolved word for
    // its address, so colliding ports all write the identical value.
    // ---------------------------------------------------------------
    logic [NUM_WR-1:0][WIDTH-1:0] wr_word;

    for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
        bram_wr_merge #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .NUM_WR (NUM_WR)
        ) u_wr_merge (
            .addr        (wr_addr[i]),
            .old_word    (mem[wr_addr[i]]),
            .wr_en       (wr_act),
            .wr_addr     (wr_addr),
            .wr_be       (wr_be),
            .wr_data     (wr_data),
            .merged_word (wr_word[i])
        );
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (wr_act[i]) begin
                    mem[wr_addr[i]] <= wr_word[i];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Read path: stage 0 word, optionally forwarded from this cycle's writes
    // ---------------------------------------------------------------
    logic [NUM_RD-1:0][WIDTH-1:0] rd_word;

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        if (RdwMode == bram_pkg::RDW_NEW) begin : g_fwd
            bram_wr_merge #(
                .WIDTH  (WIDTH),
                .DEPTH  (DEPTH),
                .NUM_WR (NUM_WR)
            ) u_fwd_merge (
                .addr        (rd_addr[j]),
                .old_word    (mem[rd_addr[j]]),
                .wr_en       (wr_act),
                .wr_addr     (wr_addr),
                .wr_be       (wr_be),
                .wr_data     (wr_data),
                .merged_word (rd_word[j])
            );
        end else begin : g_old
            assign rd_word[j] = mem[rd_addr[j]];
        end
    end

    // Each stage's data only moves with a valid token, so the last stage
    // (and hence rd_data) holds its value between results.
    logic [NUM_RD-1:0][RD_LATENCY-1:0]            vld_q;
    logic [NUM_RD-1:0][RD_LATENCY-1:0][WIDTH-1:0] dat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_RD; j++) begin
                vld_q[j][0] <= rd_req[j];
                if (rd_req[j]) begin
                    dat_q[j][0] <= rd_word[j];
                end
                for (int unsigned s = 1; s < RD_LATENCY; s++) begin
                    vld_q[j][s] <= vld_q[j][s-1];
                    if (vld_q[j][s-1]) begin
                        dat_q[j][s] <= dat_q[j][s-1];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < NUM_RD; j++) begin
            rd_valid[j] = vld_q[j][RD_LATENCY-1];
            rd_data[j]  = dat_q[j][RD_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_bram_mp_pipe.sv
// Bench for bram_mp_pipe: three instances (latency 1/old, 3/new, 2/old) share
// one stimulus stream; a word-level reference memory predicts every output.
module tb_bram_mp_pipe;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AW = 5;
    localparam int ND = 3;
    localparam int HN = 4096;

    localparam int LAT  [ND] = '{1, 3, 2};
    localparam bit RDWN [ND] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0]          rd_en;
    logic [NR-1:0][AW-1:0]  rd_addr;
    logic [NW-1:0]          wr_en;
    logic [NW-1:0][AW-1:0]  wr_addr;
    logic [NW-1:0][3:0]     wr_be;
    logic [NW-1:0][W-1:0]   wr_data;

    logic [NR-1:0][W-1:0]   rd_data   [ND];
    logic [NR-1:0]          rd_valid  [ND];
    logic                   init_busy [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        bram_mp_pipe #(
            .WIDTH          (W),
            .DEPTH          (D),
            .NUM_RD         (NR),
            .NUM_WR         (NW),
            .RD_LATENCY     (LAT[g]),
            .RDW_NEW        (RDWN[g]),
            .CLEAR_ON_RESET (1'b1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .rd_en     (rd_en),
            .rd_addr   (rd_addr),
            .rd_data   (rd_data[g]),
            .rd_valid  (rd_valid[g]),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_be     (wr_be),
            .wr_data   (wr_data),
            .init_busy (init_busy[g])
        );
    end

    // Reference model state
    logic [W-1:0] mem [D];
    int           busy_left;
    int           cyc;
    int           rst_last;
    bit           in_rst;
    bit           hv    [HN][NR];
    logic [W-1:0] h_old [HN][NR];
    logic [W-1:0] h_new [HN][NR];
    logic [W-1:0] last  [ND][NR];

    int passed;
    int total;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic idle();
        rd_en   = '0;
        rd_addr = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_be   = '0;
        wr_data = '0;
    endtask

    // One clock: model the edge, then compare every output 1 time unit later.
    task automatic tick();
        int           c;
        int           k;
        bit           ev;
        logic [W-1:0] w;
        @(posedge clk);
        c = cyc % HN;
        if (in_rst) begin
            for (int j = 0; j < NR; j++) hv[c][j] = 1'b0;
            rst_last = cyc;
        end else if (busy_left > 0) begin
            for (int j = 0; j < NR; j++) hv[c][j] = 1'b0;
            busy_left--;
        end else begin
            for (int j = 0; j < NR; j++) begin
                hv[c][j]    = rd_en[j];
                h_old[c][j] = mem[rd_addr[j]];
                w = mem[rd_addr[j]];
                for (int i = 0; i < NW; i++)
                    for (int b = 0; b < 4; b++)
                        if (wr_en[i] && wr_addr[i] == rd_addr[j] && wr_be[i][b])
                            w[8*b +: 8] = wr_data[i][8*b +: 8];
                h_new[c][j] = w;
            end
            for (int i = 0; i < NW; i++)
                for (int b = 0; b < 4; b++)
                    if (wr_en[i] && wr_be[i][b])
                        mem[wr_addr[i]][8*b +: 8] = wr_data[i][8*b +: 8];
        end
        #1;
        for (int d = 0; d < ND; d++) begin
            for (int j = 0; j < NR; j++) begin
                k  = cyc - LAT[d] + 1;
                ev = (k > rst_last) && hv[k % HN][j];
                if (ev) last[d][j] = RDWN[d] ? h_new[k % HN][j] : h_old[k % HN][j];
                check($sformatf("rd_valid d%0d p%0d cyc%0d", d, j, cyc),
                      32'(rd_valid[d][j]), 32'(ev));
                check($sformatf("rd_data d%0d p%0d cyc%0d", d, j, cyc),
                      rd_data[d][j], last[d][j]);
            end
            check($sformatf("init_busy d%0d cyc%0d", d, cyc), 32'(init_busy[d]),
                  32'(in_rst || busy_left > 0));
        end
        cyc++;
    endtask

    task automatic assert_reset();
        reset  = 1'b0;
        in_rst = 1'b1;
        for (int d = 0; d < ND; d++)
            for (int j = 0; j < NR; j++) last[d][j] = '0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst rd_valid d%0d", d), 32'(rd_valid[d]), 32'd0);
            check($sformatf("rst rd_data d%0d", d), rd_data[d][0] | rd_data[d][1], 32'd0);
            check($sformatf("rst init_busy d%0d", d), 32'(init_busy[d]), 32'd1);
        end
    endtask

    task automatic release_reset();
        reset     = 1'b1;
        in_rst    = 1'b0;
        busy_left = D;
        for (int a = 0; a < D; a++) mem[a] = '0;
    endtask

    task automatic wr1(input int p, input int a, input logic [W-1:0] dat, input logic [3:0] be);
        wr_en[p]   = 1'b1;
        wr_addr[p] = AW'(a);
        wr_data[p] = dat;
        wr_be[p]   = be;
    endtask

    task automatic rd1(input int p, input int a);
        rd_en[p]   = 1'b1;
        rd_addr[p] = AW'(a);
    endtask

    // Issue nothing for a few cycles so every pipeline drains and rd_data holds.
    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    initial begin
        int n;
        passed   = 0;
        total    = 0;
        cyc      = 0;
        rst_last = -1;
        idle();
        assert_reset();
        repeat (3) tick();
        release_reset();

        // Clear length after reset release
        n = 0;
        while (init_busy[0] === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("clear_len", 32'(n), 32'd32);

        // Every address reads zero after the clear
        for (int a = 0; a < D; a++) begin
            idle();
            rd1(0, a);
            rd1(1, D - 1 - a);
            tick();
        end
        drain();

        // Reset ten cycles into the clear, then attempt writes while busy
        assert_reset();
        repeat (2) tick();
        release_reset();
        repeat (10) tick();
        assert_reset();
        tick();
        release_reset();
        n = 0;
        while (init_busy[0] === 1'b1 && n < 100) begin
            idle();
            wr1(0, 9, 32'h5555_5555, 4'hF);
            wr1(1, 30, 32'h6666_6666, 4'hF);
            rd1(0, 9);
            tick();
            n++;
        end
        check("reclear_len", 32'(n), 32'd32);
        idle();
        rd1(0, 9);
        rd1(1, 30);
        tick();
        drain();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("busy_wr_dropped d%0d", d), rd_data[d][0], 32'h0);
            check($sformatf("busy_wr_dropped2 d%0d", d), rd_data[d][1], 32'h0);
        end

        // Byte enables
        idle(); wr1(0, 5, 32'hAABB_CCDD, 4'b1111); tick();
        idle(); wr1(0, 5, 32'h1122_3344, 4'b0101); tick();
        idle(); rd1(0, 5); tick();
        drain();
        for (int d = 0; d < ND; d++)
            check($sformatf("be_merge d%0d", d), rd_data[d][0], 32'hAA22_CC44);

        // Full and partial collisions
        idle(); wr1(0, 7, 32'h1111_1111, 4'hF); wr1(1, 7, 32'h2222_2222, 4'hF); tick();
        idle(); wr1(0, 8, 32'hAAAA_AAAA, 4'hF); wr1(1, 8, 32'hBBBB_BBBB, 4'b0011); tick();
        idle(); rd1(1, 7); rd1(0, 8); tick();
        drain();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("collision d%0d", d), rd_data[d][1], 32'h2222_2222);
            check($sformatf("collision_part d%0d", d), rd_data[d][0], 32'hAAAA_BBBB);
        end

        // Read-during-write, full word then low half
        idle(); wr1(0, 3, 32'hDEAD_BEEF, 4'hF); rd1(0, 3); tick();
        drain();
        for (int d = 0; d < ND; d++)
            check($sformatf("rdw_full d%0d", d), rd_data[d][0],
                  RDWN[d] ? 32'hDEAD_BEEF : 32'h0);
        idle(); wr1(1, 4, 32'hDEAD_BEEF, 4'b0011); rd1(0, 4); tick();
        drain();
        for (int d = 0; d < ND; d++)
            check($sformatf("rdw_part d%0d", d), rd_data[d][0],
                  RDWN[d] ? 32'h0000_BEEF : 32'h0);

        // Pipelining: a later write must not touch reads already in flight
        for (int a = 0; a < 4; a++) begin
            idle(); wr1(1, a, 32'(10 + a), 4'hF); tick();
        end
        for (int a = 0; a < 4; a++) begin
            idle(); rd1(0, a);
            if (a == 3) wr1(0, 0, 32'h0BAD_0BAD, 4'hF);
            tick();
        end
        drain();
        for (int d = 0; d < ND; d++)
            check($sformatf("pipe_last d%0d", d), rd_data[d][0], 32'd13);

        // Randomized traffic on a narrow address window to force collisions
        for (int r = 0; r < 400; r++) begin
            for (int j = 0; j < NR; j++) begin
                rd_en[j]   = 1'($urandom);
                rd_addr[j] = AW'($urandom_range(0, 7));
            end
            for (int i = 0; i < NW; i++) begin
                wr_en[i]   = 1'($urandom);
                wr_addr[i] = AW'($urandom_range(0, 7));
                wr_be[i]   = 4'($urandom);
                wr_data[i] = $urandom;
            end
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bram_mp_pipe.md
Name: bram_mp_pipe

Overview:
- Generalised multi-port on-chip RAM. Replaces the fixed 2-port read/write BRAM in the register-file and queue storage paths.
- Separate counts of read and write ports, per-byte write enables, and a configurable read pipeline with valid tracking.
- Selectable read-during-write semantics with deterministic multi-writer collision priority.
- Built-in clear sequencer zeroes the array after reset.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; must be a power of 2, at least 2.
- NUM_RD, 2, number of read ports, at least 1.
- NUM_WR, 2, number of write ports, at least 1.
- RD_LATENCY, 1, cycles from rd_en to rd_valid; legal range 1..3.
- RDW_NEW, 0, read-during-write behaviour: 0 returns old data, 1 returns new (forwarded) data.
- CLEAR_ON_RESET, 1, 1 enables the post-reset zeroing sequence.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_en  in  [NUM_RD] x 1  read request.
- rd_addr  in  [NUM_RD] x $clog2(DEPTH)  read address.
- rd_data  out  [NUM_RD] x WIDTH  read data.
- rd_valid  out  [NUM_RD] x 1  rd_data qualifier.
- wr_en  in  [NUM_WR] x 1  write request.
- wr_addr  in  [NUM_WR] x $clog2(DEPTH)  write address.
- wr_be  in  [NUM_WR] x WIDTH/8  byte enables; bit b covers data[8b+7:8b].
- wr_data  in  [NUM_WR] x WIDTH  write data.
- init_busy  out  1  clear sequence in progress.

Behaviour:
- Reset (reset low, asynchronous):
  - rd_valid all 0 and rd_data all 0.
  - All pipeline stages flushed.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else to READY. The clear counter goes to 0.
  - init_busy is 1 during reset when CLEAR_ON_RESET=1.
  - Array contents are not reset directly.
- FSM has two states, CLEAR and READY.
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. On cnt==DEPTH-1 the FSM moves to READY the next cycle.
  - The clear therefore takes exactly DEPTH cycles after reset release. init_busy=1 throughout CLEAR.
  - READY: init_busy=0. The FSM stays in READY until the next reset.
  - Reset asserted mid-clear restarts the clear from address 0.
- While init_busy=1:
  - wr_en and rd_en are ignored; no write occurs.
  - rd_valid stays 0.
- Write, per port i with wr_en[i]=1:
  - On the clk edge, each byte b with wr_be[i][b]=1 updates mem[wr_addr[i]] byte b. Bytes with wr_be=0 keep their value.
  - wr_en=1 with wr_be=0 is a legal no-op.
- Write collision (same address, same cycle): resolved per byte. The highest-index port asserting that byte wins; other ports' bytes are discarded.
- Read, per port j:
  - Stage 0 samples the array and the read-during-write result at the rd_en edge.
  - rd_valid[j]=1 exactly RD_LATENCY cycles after the rd_en[j] cycle, for one cycle per request.
  - Back-to-back reads are fully pipelined: one result per cycle per port.
  - rd_data holds its last value when rd_valid=0.
- Read-during-write, same cycle and same address:
  - RDW_NEW=0: returns the pre-write word.
  - RDW_NEW=1: returns the merged word after collision priority and byte enables; unwritten bytes come from the old word.
  - A write in a later cycle, while an earlier read is still in the pipeline, does NOT affect that read's data.
- Address width is exactly $clog2(DEPTH), so out-of-range addresses cannot occur.

Decomposition:
- Shared package bram_pkg:
  - Typedef rdw_mode_e with RDW_OLD=0 and RDW_NEW=1.
  - Typedef clr_state_e with CLEAR and READY.
  - Function byte_merge(old, new, be) returning the merged word.
- Sub-module bram_wr_merge: combinational per-address collision resolver and byte merger. Shared by the array write path and the RDW_NEW forwarding path so both always agree.
- Read pipeline and FSM are inline in bram_mp_pipe.

Test Plan:
- Clear: DEPTH=32, CLEAR_ON_RESET=1, release reset → init_busy=1 for exactly 32 cycles then 0; reading every address afterwards returns 0x00000000.
- Reset mid-clear: assert reset at clear cycle 10, release → init_busy=1 for a further 32 cycles; writes attempted while busy do not land.
- Byte enables:
  - Write 0xAABBCCDD to addr 5 with be=4'b1111.
  - Then write 0x11223344 to addr 5 with be=4'b0101.
  - Read addr 5 → 0xAA22CC44, with rd_valid exactly RD_LATENCY cycles after rd_en; repeat for RD_LATENCY=1, 2, 3.
- Collision: ports 0 and 1 write addr 7 in the same cycle with 0x11111111 and 0x22222222, be=1111 → addr 7 reads 0x22222222.
- Read-during-write:
  - addr 3 holds 0x0; write 0xDEADBEEF to addr 3 while reading addr 3 in the same cycle.
  - RDW_NEW=0 returns 0x00000000; RDW_NEW=1 returns 0xDEADBEEF.
  - With be=0011 and RDW_NEW=1, the same read returns 0x0000BEEF.
- Pipelining: RD_LATENCY=3, rd_en high for 4 consecutive cycles on addrs 0..3 holding 10, 11, 12, 13 → rd_valid high for 4 consecutive cycles starting at cycle 3, data 10, 11, 12, 13 in order.
